// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multicycle divide stall, taken-branch flush,
// WB->EX forwarding selects and saturating stall/flush performance counters.
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [4:0]  ex_rs1,
   input  logic [4:0]  ex_rs2,
   input  logic        ex_uses_rs1,
   input  logic        ex_uses_rs2,
   input  logic        ex_branch_taken,
   input  logic        ex_div_req,
   input  logic [4:0]  wb_rd,
   input  logic        wb_regwrite,
   input  logic        div_done,
   output logic        div_start,
   output logic        stall_f,
   output logic        flush_ex,
   output logic        pc_sel,
   output logic        ex_adv,
   output logic        fwd_a,
   output logic        fwd_b,
   output logic        busy,
   output logic        div_timeout,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   typedef enum logic [0:0] {StRun, StDivWait} state_e;

   localparam logic [5:0]  WaitMax = 6'd63;
   localparam logic [15:0] CntMax  = 16'hFFFF;

   state_e      state_q, state_d;
   logic [5:0]  wait_cnt_q, wait_cnt_d;
   logic        div_timeout_q, div_timeout_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   // Ungated control decisions; rst_n masks them onto the ports below.
   logic div_start_c, stall_c, flush_c, pc_sel_c, ex_adv_c;

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      div_timeout_d = div_timeout_q;
      div_start_c   = 1'b0;
      stall_c       = 1'b0;
      flush_c       = 1'b0;
      pc_sel_c      = 1'b0;
      ex_adv_c      = 1'b0;

      case (state_q)
         StRun: begin
            // Divide wins over a simultaneous taken branch.
            if (ex_valid && ex_div_req) begin
               div_start_c = 1'b1;
               stall_c     = 1'b1;
               wait_cnt_d  = 6'd0;
               state_d     = StDivWait;
            end else if (ex_valid && ex_branch_taken) begin
               pc_sel_c = 1'b1;
               flush_c  = 1'b1;
               ex_adv_c = 1'b1;
            end else begin
               ex_adv_c = ex_valid;
            end
         end
         StDivWait: begin
            if (div_done) begin
               ex_adv_c = 1'b1;
               state_d  = StRun;
            end else if (wait_cnt_q == WaitMax) begin
               // Give up on the divider and let the pipeline move on.
               ex_adv_c      = 1'b1;
               div_timeout_d = 1'b1;
               state_d       = StRun;
            end else begin
               stall_c    = 1'b1;
               wait_cnt_d = wait_cnt_q + 6'd1;
            end
         end
         default: state_d = StRun;
      endcase
   end

   assign div_start = rst_n & div_start_c;
   assign stall_f   = rst_n & stall_c;
   assign flush_ex  = rst_n & flush_c;
   assign pc_sel    = rst_n & pc_sel_c;
   assign ex_adv    = rst_n & ex_adv_c;
   assign busy      = rst_n & (state_q == StDivWait);

   assign fwd_a = rst_n & wb_regwrite & (wb_rd != 5'd0) & (wb_rd == ex_rs1) & ex_uses_rs1;
   assign fwd_b = rst_n & wb_regwrite & (wb_rd != 5'd0) & (wb_rd == ex_rs2) & ex_uses_rs2;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_f && (stall_cnt_q != CntMax)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (flush_ex && (flush_cnt_q != CntMax)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StRun;
         wait_cnt_q    <= 6'd0;
         div_timeout_q <= 1'b0;
         stall_cnt_q   <= 16'd0;
         flush_cnt_q   <= 16'd0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         div_timeout_q <= div_timeout_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   assign div_timeout = div_timeout_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multicycle
// sequences and a randomized run against a cycle-level reference model.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic [4:0]  ex_rs1, ex_rs2;
   logic        ex_uses_rs1, ex_uses_rs2;
   logic        ex_branch_taken, ex_div_req;
   logic [4:0]  wb_rd;
   logic        wb_regwrite, div_done;
   logic        div_start, stall_f, flush_ex, pc_sel, ex_adv, fwd_a, fwd_b, busy;
   logic        div_timeout;
   logic [15:0] stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ex_valid        (ex_valid),
      .ex_rs1          (ex_rs1),
      .ex_rs2          (ex_rs2),
      .ex_uses_rs1     (ex_uses_rs1),
      .ex_uses_rs2     (ex_uses_rs2),
      .ex_branch_taken (ex_branch_taken),
      .ex_div_req      (ex_div_req),
      .wb_rd           (wb_rd),
      .wb_regwrite     (wb_regwrite),
      .div_done        (div_done),
      .div_start       (div_start),
      .stall_f         (stall_f),
      .flush_ex        (flush_ex),
      .pc_sel          (pc_sel),
      .ex_adv          (ex_adv),
      .fwd_a           (fwd_a),
      .fwd_b           (fwd_b),
      .busy            (busy),
      .div_timeout     (div_timeout),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   // {div_start, stall_f, flush_ex, pc_sel, ex_adv, fwd_a, fwd_b, busy}
   logic [7:0] ob;
   assign ob = {div_start, stall_f, flush_ex, pc_sel, ex_adv, fwd_a, fwd_b, busy};

   // Minimal EX instruction register stub driven by the controller outputs.
   localparam logic [31:0] Nop = 32'h00000013;
   logic [31:0] fetch_ir = 32'h00a00093;
   logic [31:0] ex_ir = 32'h0;
   always @(posedge clk) begin
      if (flush_ex)      ex_ir <= Nop;
      else if (!stall_f) ex_ir <= fetch_ir;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rst;
      logic       valid;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       br;
      logic       dv;
      logic [4:0] wbrd;
      logic       wbrw;
      logic       done;
      logic [7:0] exp;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic v, input logic [4:0] a,
                               input logic [4:0] b, input logic u1, input logic u2,
                               input logic br, input logic dv, input logic [4:0] w,
                               input logic rw, input logic dn, input logic [7:0] e);
      vec_t t;
      t.rst = r; t.valid = v; t.rs1 = a; t.rs2 = b; t.u1 = u1; t.u2 = u2;
      t.br = br; t.dv = dv; t.wbrd = w; t.wbrw = rw; t.done = dn; t.exp = e;
      return t;
   endfunction

   task automatic clear_inputs();
      ex_valid = 0; ex_rs1 = 0; ex_rs2 = 0; ex_uses_rs1 = 0; ex_uses_rs2 = 0;
      ex_branch_taken = 0; ex_div_req = 0; wb_rd = 0; wb_regwrite = 0; div_done = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0;
      clear_inputs();
      next_cycle();
      rst_n = 1;
   endtask

   vec_t tbl[$];

   // Reference model state
   bit m_div;
   int m_wait;
   bit m_to;
   int m_sc, m_fc;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   initial begin
      int ds, st, adv, adv_at, exit_k;
      logic to_before;
      logic e_ds, e_st, e_fl, e_pc, e_adv, e_fa, e_fb, e_busy;

      // ---------------- Reset behaviour ----------------
      rst_n = 0;
      clear_inputs();
      next_cycle();
      ex_valid = 1; ex_branch_taken = 1; ex_div_req = 0;
      ex_rs1 = 5'd4; ex_uses_rs1 = 1; wb_rd = 5'd4; wb_regwrite = 1;
      @(negedge clk);
      check("reset_outputs_forced", ob, 8'h00);
      check("reset_regs", {stall_cnt, flush_cnt, div_timeout}, 33'd0);
      next_cycle();
      rst_n = 1;

      // ---------------- Vector table (each applied in RUN) ----------------
      //               rst v  rs1 rs2 u1 u2 br dv wbrd rw dn  expected
      tbl.push_back(mk(1, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 8'b0000_0000));
      tbl.push_back(mk(1, 1, 1,  2,  1, 1, 0, 0, 3,  1, 0, 8'b0000_1000));
      tbl.push_back(mk(1, 1, 1,  2,  0, 0, 1, 0, 0,  0, 0, 8'b0011_1000));
      tbl.push_back(mk(1, 1, 1,  2,  0, 0, 0, 1, 0,  0, 0, 8'b1100_0000));
      tbl.push_back(mk(1, 1, 1,  2,  0, 0, 1, 1, 0,  0, 0, 8'b1100_0000));
      tbl.push_back(mk(1, 0, 1,  2,  0, 0, 1, 0, 0,  0, 0, 8'b0000_0000));
      tbl.push_back(mk(1, 0, 1,  2,  0, 0, 0, 1, 0,  0, 0, 8'b0000_0000));
      tbl.push_back(mk(1, 1, 5,  5,  1, 1, 0, 0, 5,  1, 0, 8'b0000_1110));
      tbl.push_back(mk(1, 1, 0,  0,  1, 1, 0, 0, 0,  1, 0, 8'b0000_1000));
      tbl.push_back(mk(1, 1, 5,  5,  1, 1, 0, 0, 5,  0, 0, 8'b0000_1000));
      tbl.push_back(mk(1, 1, 7,  7,  0, 1, 0, 0, 7,  1, 0, 8'b0000_1010));
      tbl.push_back(mk(1, 1, 9,  10, 1, 1, 0, 0, 9,  1, 0, 8'b0000_1100));
      tbl.push_back(mk(0, 1, 5,  5,  1, 1, 1, 0, 5,  1, 0, 8'b0000_0000));
      tbl.push_back(mk(1, 1, 1,  2,  0, 0, 0, 0, 0,  0, 1, 8'b0000_1000));
      tbl.push_back(mk(1, 0, 6,  6,  1, 1, 0, 0, 6,  1, 0, 8'b0000_0110));

      for (int i = 0; i < tbl.size(); i++) begin
         do_reset();
         rst_n = tbl[i].rst; ex_valid = tbl[i].valid;
         ex_rs1 = tbl[i].rs1; ex_rs2 = tbl[i].rs2;
         ex_uses_rs1 = tbl[i].u1; ex_uses_rs2 = tbl[i].u2;
         ex_branch_taken = tbl[i].br; ex_div_req = tbl[i].dv;
         wb_rd = tbl[i].wbrd; wb_regwrite = tbl[i].wbrw; div_done = tbl[i].done;
         @(negedge clk);
         check($sformatf("vec%0d", i), ob, tbl[i].exp);
         next_cycle();
      end

      // ---------------- Div, done at wait cycle 5 ----------------
      do_reset();
      ex_valid = 1; ex_div_req = 1;
      ds = 0; st = 0; adv = 0; adv_at = -1;
      for (int k = 0; k < 7; k++) begin
         div_done = (k == 6);
         @(negedge clk);
         ds += int'(div_start);
         st += int'(stall_f);
         if (ex_adv) begin
            adv++;
            adv_at = k;
         end
         next_cycle();
      end
      clear_inputs();
      @(negedge clk);
      check("div5_start_pulses", ds, 1);
      check("div5_stall_cycles", st, 6);
      check("div5_adv_count", adv, 1);
      check("div5_adv_cycle", adv_at, 6);
      check("div5_stall_cnt", stall_cnt, 16'd6);
      check("div5_busy_after", busy, 1'b0);

      // ---------------- Div, no done: timeout ----------------
      do_reset();
      ex_valid = 1; ex_div_req = 1;
      st = 0; exit_k = -1; to_before = 1'bx;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         st += int'(stall_f);
         if (busy && ex_adv) begin
            exit_k = k;
            to_before = div_timeout;
         end
         next_cycle();
         if (exit_k >= 0) begin
            clear_inputs();
            break;
         end
      end
      @(negedge clk);
      check("to_exit_cycle", exit_k, 64);
      check("to_stall_cycles", st, 64);
      check("to_flag_before_exit", to_before, 1'b0);
      check("to_flag_set", div_timeout, 1'b1);
      check("to_busy_after", busy, 1'b0);
      check("to_stall_cnt", stall_cnt, 16'd64);
      for (int k = 0; k < 5; k++) next_cycle();
      @(negedge clk);
      check("to_flag_sticky", div_timeout, 1'b1);

      // ---------------- Taken branch ----------------
      do_reset();
      ex_valid = 1; ex_branch_taken = 1;
      @(negedge clk);
      check("br_pcsel_flush", {pc_sel, flush_ex, ex_adv, stall_f}, 4'b1110);
      next_cycle();
      clear_inputs();
      @(negedge clk);
      check("br_one_cycle", {pc_sel, flush_ex}, 2'b00);
      check("br_flush_cnt", flush_cnt, 16'd1);
      check("br_ex_nop", ex_ir, Nop);

      // ---------------- Branch and div together ----------------
      do_reset();
      ex_valid = 1; ex_branch_taken = 1; ex_div_req = 1;
      @(negedge clk);
      check("brdiv_priority", {div_start, stall_f, pc_sel, flush_ex}, 4'b1100);
      next_cycle();
      clear_inputs();
      @(negedge clk);
      check("brdiv_busy", busy, 1'b1);
      check("brdiv_flush_cnt", flush_cnt, 16'd0);

      // ---------------- Reset at wait cycle 3 ----------------
      do_reset();
      ex_valid = 1; ex_div_req = 1;
      for (int k = 0; k < 4; k++) next_cycle();
      @(negedge clk);
      check("rst3_waiting", {busy, stall_f}, 2'b11);
      rst_n = 0;
      #1;
      check("rst3_outputs_forced", ob, 8'h00);
      next_cycle();
      rst_n = 1;
      clear_inputs();
      @(negedge clk);
      check("rst3_state_counters", {busy, div_timeout, stall_cnt, flush_cnt}, 34'd0);
      next_cycle();
      div_done = 1;
      @(negedge clk);
      check("rst3_late_done", {ex_adv, busy, stall_f}, 3'b000);
      next_cycle();
      clear_inputs();

      // ---------------- Randomized run vs reference model ----------------
      m_div = 0; m_wait = 0; m_to = 0; m_sc = 0; m_fc = 0;
      for (int n = 0; n < 4000; n++) begin
         rst_n           = (n == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
         ex_valid        = ($urandom_range(0, 3) != 0);
         ex_rs1          = 5'($urandom_range(0, 3));
         ex_rs2          = 5'($urandom_range(0, 3));
         ex_uses_rs1     = 1'($urandom_range(0, 1));
         ex_uses_rs2     = 1'($urandom_range(0, 1));
         ex_branch_taken = ($urandom_range(0, 3) == 0);
         ex_div_req      = ($urandom_range(0, 7) == 0);
         wb_rd           = 5'($urandom_range(0, 3));
         wb_regwrite     = 1'($urandom_range(0, 1));
         div_done        = ($urandom_range(0, 40) == 0);
         @(negedge clk);

         {e_ds, e_st, e_fl, e_pc, e_adv, e_fa, e_fb, e_busy} = 8'h00;
         if (rst_n) begin
            e_busy = m_div;
            e_fa = wb_regwrite && (wb_rd != 0) && (wb_rd == ex_rs1) && ex_uses_rs1;
            e_fb = wb_regwrite && (wb_rd != 0) && (wb_rd == ex_rs2) && ex_uses_rs2;
            if (!m_div) begin
               if (ex_valid && ex_div_req) begin
                  e_ds = 1; e_st = 1;
               end else if (ex_valid && ex_branch_taken) begin
                  e_pc = 1; e_fl = 1; e_adv = 1;
               end else begin
                  e_adv = ex_valid;
               end
            end else if (div_done || m_wait == 63) begin
               e_adv = 1;
            end else begin
               e_st = 1;
            end
         end
         check($sformatf("rand%0d_ctrl", n), ob,
               {e_ds, e_st, e_fl, e_pc, e_adv, e_fa, e_fb, e_busy});
         if (n > 0) begin
            check($sformatf("rand%0d_regs", n), {stall_cnt, flush_cnt, div_timeout},
                  {16'(m_sc), 16'(m_fc), m_to});
         end

         if (!rst_n) begin
            m_div = 0; m_wait = 0; m_to = 0; m_sc = 0; m_fc = 0;
         end else begin
            if (e_st && m_sc < 65535) m_sc++;
            if (e_fl && m_fc < 65535) m_fc++;
            if (!m_div) begin
               if (e_ds) begin
                  m_div = 1;
                  m_wait = 0;
               end
            end else if (div_done) begin
               m_div = 0;
            end else if (m_wait == 63) begin
               m_div = 0;
               m_to = 1;
            end else begin
               m_wait++;
            end
         end
         next_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL be clocked and reset as follows: reset rst_n, synchronous, active-low; clock clk.
REQ-002 Ports SHALL be, clock and reset first (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_rs1, ex_rs2  in  5 each  EX source register addresses.
- ex_uses_rs1, ex_uses_rs2  in  1 each  EX instruction reads that source.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- ex_div_req  in  1  EX instruction is a multicycle div/rem.
- wb_rd  in  5  WB destination register.
- wb_regwrite  in  1  WB instruction writes the register file.
- div_done  in  1  divider result valid, one-cycle pulse.
- div_start  out  1  one-cycle pulse launching the divider.
- stall_f  out  1  hold PC_F and the EX instruction register.
- flush_ex  out  1  load NOP (32'h00000013) into the EX instruction register at the next edge.
- pc_sel  out  1  1 = load PC_F from the branch target.
- ex_adv  out  1  EX instruction advances into WB; 0 = WB pipeline registers take a bubble (regwrite_WB=0, gpio_we_WB=0).
- fwd_a, fwd_b  out  1 each  select WB write data instead of readdata1/readdata2.
- busy  out  1  state is not RUN.
- div_timeout  out  1  sticky divider-timeout error.
- stall_cnt, flush_cnt  out  16 each  saturating performance counters.

Function
REQ-003 The FSM SHALL have exactly two states: RUN and DIV_WAIT.
REQ-004 In RUN with ex_valid=1 and ex_div_req=1, the block SHALL assert div_start=1, stall_f=1 and ex_adv=0 in the same cycle, and SHALL enter DIV_WAIT at the next edge.
REQ-005 In DIV_WAIT, stall_f SHALL be 1 and ex_adv SHALL be 0 every cycle until the exit cycle, and div_start SHALL be 0.
REQ-006 In DIV_WAIT, the cycle in which div_done=1 SHALL be the exit cycle: stall_f=0, ex_adv=1, next state RUN.
REQ-007 A 6-bit wait counter SHALL clear on entry to DIV_WAIT and increment each DIV_WAIT cycle without div_done.
REQ-008 When the wait counter equals 63 without div_done, that cycle SHALL be an exit cycle (as REQ-006) and div_timeout SHALL set; div_timeout SHALL stay 1 until reset.
REQ-009 div_done while in RUN SHALL be ignored.
REQ-010 In RUN with ex_valid=1, ex_branch_taken=1 and ex_div_req=0, the block SHALL assert pc_sel=1, flush_ex=1, ex_adv=1 and stall_f=0.
REQ-011 If ex_div_req and ex_branch_taken are both 1, div SHALL have priority: pc_sel=0 and flush_ex=0.
REQ-012 ex_branch_taken SHALL be ignored in DIV_WAIT.
REQ-013 In RUN with no div or branch, the block SHALL drive ex_adv=ex_valid and all other control outputs 0.
REQ-014 fwd_a SHALL equal wb_regwrite & (wb_rd!=0) & (wb_rd==ex_rs1) & ex_uses_rs1, combinationally in every state.
REQ-015 fwd_b SHALL follow the same rule as fwd_a using ex_rs2 and ex_uses_rs2.
REQ-016 busy SHALL be 1 exactly when the state is DIV_WAIT.
REQ-017 stall_cnt SHALL increment on every cycle with stall_f=1 and SHALL saturate at 16'hFFFF.
REQ-018 flush_cnt SHALL increment on every cycle with flush_ex=1 and SHALL saturate at 16'hFFFF.

Reset
REQ-019 While rst_n=0 at a rising edge, the block SHALL set state=RUN, wait counter=0, div_timeout=0, stall_cnt=0 and flush_cnt=0.
REQ-020 In any cycle with rst_n=0, div_start, stall_f, flush_ex, pc_sel, ex_adv, fwd_a, fwd_b and busy SHALL be forced to 0.
REQ-021 A reset asserted during DIV_WAIT SHALL abandon the divide; a later div_done SHALL be ignored per REQ-009.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Div, done at wait cycle 5: div_start pulses once; stall_f=1 for 6 cycles; ex_adv=1 only on the done cycle; stall_cnt=6.
- Div, no done: exit at wait counter 63; div_timeout=1 and stays 1; busy=0 afterwards.
- Taken branch: pc_sel=flush_ex=1 for one cycle; flush_cnt=1; next EX instruction is NOP.
- Branch and div together: div wins; pc_sel=flush_ex=0; state goes to DIV_WAIT.
- Forwarding: wb_rd=5, wb_regwrite=1, ex_rs1=ex_rs2=5 -> fwd_a=fwd_b=1; same with wb_rd=0 -> both 0.
- Reset at wait cycle 3: next cycle state=RUN, all counters 0; a div_done two cycles later produces no ex_adv change.
